// File: rtl/instr_rom_param_if.sv
// -----------------------------------------------------------------------------
// instr_rom_param_if
// Purpose : groups the program-load and fetch signals of instr_rom_param so
//           the ROM and its driver connect through a single bundle.
// Modports:
//   master - drives load_start, load_we, load_data, load_done, pc_in,
//            fetch_req and stall; observes the fetch response.
//   slave  - the ROM itself; drives instr_out, instr_valid, addr_err,
//            loading and parity_err.
// Parameters: INSTR_W (instruction width), PC_W (fetch address width).
// -----------------------------------------------------------------------------
interface instr_rom_param_if #(
  parameter int INSTR_W = 9,
  parameter int PC_W    = 16
);
  logic               load_start;
  logic               load_we;
  logic [INSTR_W-1:0] load_data;
  logic               load_done;
  logic [PC_W-1:0]    pc_in;
  logic               fetch_req;
  logic               stall;
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic               addr_err;
  logic               loading;
  logic               parity_err;

  modport master (
    output load_start, load_we, load_data, load_done, pc_in, fetch_req, stall,
    input  instr_out, instr_valid, addr_err, loading, parity_err
  );

  modport slave (
    input  load_start, load_we, load_data, load_done, pc_in, fetch_req, stall,
    output instr_out, instr_valid, addr_err, loading, parity_err
  );
endinterface

// File: rtl/instr_rom_param.sv
// -----------------------------------------------------------------------------
// instr_rom_param
// Purpose : loadable instruction store. A program is streamed in while in
//           LOAD, then fetched with a one-cycle registered latency in RUN.
//           Memory contents survive reset.
// Ports   :
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset (clears control/outputs only)
//   bus    - instr_rom_param_if.slave: load_start/load_we/load_data/
//            load_done (program load), pc_in/fetch_req/stall (fetch),
//            instr_out/instr_valid/addr_err/loading/parity_err (response)
// Parameters: INSTR_W word width, DEPTH word count (2..65536), PC_W pc width.
// Build option: define INSTR_ROM_PARITY_EN to store an even-parity bit with
//           each word and flag mismatches on read through parity_err.
//           Without it, parity_err is constant 0.
// -----------------------------------------------------------------------------
module instr_rom_param #(
  parameter int INSTR_W = 9,
  parameter int DEPTH   = 64,
  parameter int PC_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  instr_rom_param_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef INSTR_ROM_PARITY_EN
  localparam int STORE_W = INSTR_W + 1;
`else
  localparam int STORE_W = INSTR_W;
`endif

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]         state;
  logic [1:0]         next_state;
  logic [PTR_W-1:0]   wr_ptr;
  logic               wr_en;
  logic               wr_last;
  logic [STORE_W-1:0] wr_word;
  logic [PTR_W-1:0]   rd_idx;
  logic [STORE_W-1:0] rd_word;
  logic               pc_oob;
  logic               rd_perr;

  logic [STORE_W-1:0] mem [DEPTH];

  logic [INSTR_W-1:0] instr_q;
  logic               valid_q;
  logic               addr_err_q;
  logic               perr_q;
  logic               loading_q;

  // Write side: a strobe only counts while loading, and the word at
  // DEPTH-1 is the last one accepted before the FSM moves on to RUN.
  always_comb begin
    wr_en   = (state == ST_LOAD) && bus.load_we;
    wr_last = (wr_ptr == PTR_W'(DEPTH - 1));
`ifdef INSTR_ROM_PARITY_EN
    wr_word = {^bus.load_data, bus.load_data};
`else
    wr_word = bus.load_data;
`endif
  end

  // Read side: the wide compare keeps the range check correct even when
  // DEPTH equals 2**PC_W; out-of-range addresses never reach the array.
  always_comb begin
    pc_oob = (64'(bus.pc_in) >= 64'(DEPTH));
    rd_idx = PTR_W'(bus.pc_in);
    rd_word = '0;
    if (!pc_oob) begin
      rd_word = mem[rd_idx];
    end
`ifdef INSTR_ROM_PARITY_EN
    rd_perr = ^rd_word;
`else
    rd_perr = 1'b0;
`endif
  end

  // Next-state logic. A write that lands on the last address ends the load
  // just as load_done does; the word itself is still written that cycle.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (bus.load_start) next_state = ST_LOAD;
      ST_LOAD: if ((wr_en && wr_last) || bus.load_done) next_state = ST_RUN;
      ST_RUN:  if (bus.load_start) next_state = ST_LOAD;
      default: next_state = ST_IDLE;
    endcase
  end

  // Control state and write pointer. The pointer is cleared on every entry
  // into LOAD and saturates at DEPTH-1 rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      loading_q <= 1'b0;
    end else begin
      state     <= next_state;
      loading_q <= (next_state == ST_LOAD);
      if (state != ST_LOAD && next_state == ST_LOAD) begin
        wr_ptr <= '0;
      end else if (wr_en && !wr_last) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
    end
  end

  // Storage array has no reset so a program survives a reset pulse; reset
  // still blocks a write in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  // Fetch response. Outside RUN, or when RUN is being left for a reload,
  // there is no response. Stall freezes everything; instr_out only changes
  // when a real read is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q    <= '0;
      valid_q    <= 1'b0;
      addr_err_q <= 1'b0;
      perr_q     <= 1'b0;
    end else if (state != ST_RUN || bus.load_start) begin
      valid_q    <= 1'b0;
      addr_err_q <= 1'b0;
      perr_q     <= 1'b0;
    end else if (bus.stall) begin
      instr_q    <= instr_q;
      valid_q    <= valid_q;
      addr_err_q <= addr_err_q;
      perr_q     <= perr_q;
    end else if (bus.fetch_req) begin
      valid_q <= 1'b1;
      if (pc_oob) begin
        instr_q    <= '0;
        addr_err_q <= 1'b1;
        perr_q     <= 1'b0;
      end else begin
        instr_q    <= rd_word[INSTR_W-1:0];
        addr_err_q <= 1'b0;
        perr_q     <= rd_perr;
      end
    end else begin
      valid_q    <= 1'b0;
      addr_err_q <= 1'b0;
      perr_q     <= 1'b0;
    end
  end

  assign bus.instr_out   = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.addr_err    = addr_err_q;
  assign bus.parity_err  = perr_q;
  assign bus.loading     = loading_q;

endmodule

// File: doc/instr_rom_param.md
INSTR_ROM_PARAM -- requirements
Module: instr_rom_param

Interface
REQ-001 Parameter INSTR_W, default 9, instruction word width in bits.
REQ-002 Parameter DEPTH, default 64, number of instruction words; legal range 2..65536.
REQ-003 Parameter PC_W, default 16, program-counter width in bits.
REQ-004 The module SHALL have a single clock; reset SHALL be synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 load_start  input  1  single-cycle pulse that begins a program load.
REQ-008 load_we  input  1  load-data strobe, honoured only in LOAD.
REQ-009 load_data  input  INSTR_W  instruction word written at the internal write pointer.
REQ-010 load_done  input  1  single-cycle pulse that ends a load early.
REQ-011 pc_in  input  PC_W  fetch address.
REQ-012 fetch_req  input  1  fetch request.
REQ-013 stall  input  1  hold request; freezes all fetch outputs.
REQ-014 instr_out  output  INSTR_W  fetched instruction.
REQ-015 instr_valid  output  1  instr_out holds a response.
REQ-016 addr_err  output  1  current response came from an out-of-range pc_in.
REQ-017 loading  output  1  high while the FSM is in LOAD.
REQ-018 parity_err  output  1  parity mismatch on the current response; tied 0 without the macro.

Function
REQ-019 The FSM SHALL have three states: IDLE, LOAD and RUN.
REQ-020 Transition IDLE->LOAD occurs on load_start; the write pointer is cleared to 0 on entry.
REQ-021 In LOAD, load_we SHALL write load_data to mem[wr_ptr] and then increment wr_ptr.
REQ-022 Transition LOAD->RUN occurs on load_done, or on the load_we that writes address DEPTH-1; wr_ptr never wraps.
REQ-023 When load_we and load_done occur in the same cycle, the word SHALL be written first and the FSM then enters RUN.
REQ-024 In RUN, load_start SHALL re-enter LOAD, clear wr_ptr, and drive instr_valid to 0 on the next cycle.
REQ-025 In RUN, fetch_req=1 and stall=0 in cycle N SHALL produce instr_out=mem[pc_in] and instr_valid=1 in cycle N+1 (1-cycle registered latency).
REQ-026 In RUN, fetch_req=0 and stall=0 SHALL give instr_valid=0 on the next cycle; instr_out holds its last value.
REQ-027 While stall=1, instr_out, instr_valid, addr_err and parity_err SHALL hold their values and no read is issued; stall overrides fetch_req.
REQ-028 A fetch with pc_in >= DEPTH SHALL return instr_out=0 (NOP), instr_valid=1 and addr_err=1; addr_err is 0 for in-range fetches.
REQ-029 In IDLE and LOAD, fetch_req SHALL be ignored and instr_valid SHALL be 0.
REQ-030 load_we outside LOAD SHALL be ignored, and memory SHALL remain unchanged.
REQ-031 loading SHALL equal (state==LOAD), registered.

Reset
REQ-032 Reset SHALL set state=IDLE, wr_ptr=0, instr_out=0, instr_valid=0, addr_err=0, parity_err=0 and loading=0.
REQ-033 Reset SHALL NOT clear memory contents; words written before a reset, including one asserted mid-load, are retained.
REQ-034 Reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-035 Macro INSTR_ROM_PARITY_EN.
- Defined: each stored word carries one even-parity bit computed at write time and checked on read.
- Defined: a mismatch sets parity_err=1 with that response; instr_out still presents the stored data.
- Undefined: storage is INSTR_W bits wide and parity_err is constant 0.

Verification
REQ-036 Load sequence: reset, load_start, then 3 load_we writes of 0x001, 0x110, 0x010, then load_done -> RUN; fetch pc_in=1 -> next cycle instr_out=0x110, instr_valid=1.
REQ-037 Full load: DEPTH=64, 64 consecutive load_we with no load_done -> loading falls after the 64th write; fetch pc_in=63 returns the 64th word.
REQ-038 Out of range: in RUN, fetch pc_in=64 (DEPTH=64) -> instr_out=0, addr_err=1, instr_valid=1; next fetch pc_in=0 -> addr_err=0.
REQ-039 Stall: fetch pc_in=2, then stall=1 for 3 cycles with pc_in=0 -> instr_out stays mem[2] and instr_valid stays 1 throughout.
REQ-040 Reset mid-load: after 2 writes, assert reset -> state=IDLE, instr_valid=0; reload 1 word, fetch pc_in=1 -> returns the earlier second word.
REQ-041 Parity (macro defined): force-flip a stored bit, fetch it -> parity_err=1; fetch a clean word -> parity_err=0.
